// File: rtl/qmult_rr_arbiter.sv
// qmult_rr_arbiter: round-robin arbiter sharing one 2-stage Q-format signed multiplier between requesters.
// Define QMULT_ARB_SATURATE_EN to clamp overflowing results instead of wrapping.
module qmult_rr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          busy_o
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [ID_WIDTH-1:0]   ptr;
    logic                  s1_valid;
    logic [PW-1:0]         s1_prod;
    logic [ID_WIDTH-1:0]   s1_id;
    logic                  stall;
    logic                  s1_accept;
    logic                  grant_any;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   cand;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         sum;
    logic [DATA_WIDTH-1:0] result;

    assign stall     = rsp_valid_o && !rsp_ready_i;
    // S1 can take a new operand when it is empty or when it drains into S2 this cycle
    assign s1_accept = rst_ni && (!s1_valid || !stall);
    assign busy_o    = s1_valid || rsp_valid_o;

    // Scan from the farthest offset down so the first valid requester at or after ptr wins
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (req_valid_i[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign req_ready_o = (grant_any && s1_accept) ? NUM_REQ'(1) << grant_id : '0;
    assign op_a = req_a_i[int'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
    assign op_b = req_b_i[int'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
    assign prod = $signed({{DATA_WIDTH{op_a[DATA_WIDTH-1]}}, op_a})
                * $signed({{DATA_WIDTH{op_b[DATA_WIDTH-1]}}, op_b});
    assign sum  = s1_prod + (PW'(1) << (FRACTIONAL_BITS - 1));

`ifdef QMULT_ARB_SATURATE_EN
    logic signed [PW-1:0] sh;
    logic                 ovf;
    // Bits above the result's sign bit must all match it, otherwise the value does not fit
    assign sh     = $signed(sum) >>> (DATA_WIDTH + FRACTIONAL_BITS - 1);
    assign ovf    = !(sh == '0 || sh == '1);
    assign result = !ovf ? DATA_WIDTH'(sum >> FRACTIONAL_BITS)
                  : sum[PW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    assign result = DATA_WIDTH'(sum >> FRACTIONAL_BITS);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr         <= '0;
            s1_valid    <= 1'b0;
            s1_prod     <= '0;
            s1_id       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_data_o  <= '0;
        end else begin
            if (s1_accept) begin
                s1_valid <= grant_any;
                if (grant_any) begin
                    s1_prod <= prod;
                    s1_id   <= grant_id;
                    ptr     <= ID_WIDTH'((int'(grant_id) + 1) % NUM_REQ);
                end
            end
            if (!stall) begin
                rsp_valid_o <= s1_valid;
                if (s1_valid) begin
                    rsp_data_o <= result;
                    rsp_id_o   <= s1_id;
                end
            end
        end
    end
endmodule
